piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 sync_rst  input  1  reset, synchronous, active-high; sampled on posedge clk.
REQ-005 in_valid  input  1  upstream word offered.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  WIDTH  parallel word; sampled only on in_valid && in_ready.
REQ-008 ser_out  output  1  current serial bit.
REQ-009 ser_valid  output  1  ser_out carries a valid bit.
REQ-010 ser_last  output  1  current bit is the final bit of the word.
REQ-011 ser_ready  input  1  downstream accepts the current bit.

Function
REQ-012 Two states SHALL exist: IDLE (no word held) and SHIFT (word held, bits pending).
REQ-013 Word transfer SHALL occur on a cycle with in_valid && in_ready; bit transfer SHALL occur on a cycle with ser_valid && ser_ready.
REQ-014 Bit counter SHALL be $clog2(WIDTH) bits wide, counting 0..WIDTH-1; it SHALL never wrap past WIDTH-1 inside a word.
REQ-015 IDLE: in_ready = 1, ser_valid = 0, ser_last = 0; on word transfer, load in_data into shift register, counter = 0, next state SHIFT.
REQ-016 Latency: first bit SHALL be presented (ser_valid = 1) in the cycle after the word transfer.
REQ-017 SHIFT: ser_valid = 1; ser_out = shift-register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
REQ-018 SHIFT with ser_ready = 0: shift register, counter, ser_out and ser_last SHALL hold unchanged.
REQ-019 SHIFT, bit transfer, counter < WIDTH-1: shift register shifts one position toward the output end with 0 filled in; counter increments.
REQ-020 ser_last = 1 exactly when in SHIFT and counter == WIDTH-1.
REQ-021 in_ready in SHIFT = ser_last && ser_ready (combinational on ser_ready); 0 otherwise.
REQ-022 Last bit transferred with a simultaneous word transfer: load new word, counter = 0, remain SHIFT; no idle cycle between words.
REQ-023 Last bit transferred without a word transfer: next state IDLE.
REQ-024 in_data SHALL be ignored whenever in_ready = 0; in_valid without in_ready SHALL not alter state.
REQ-025 Sustained throughput SHALL be one bit per clock when ser_ready is held 1 and in_valid is presented on each last-bit cycle.

Reset
REQ-026 With sync_rst = 1 at a posedge: state = IDLE, shift register = 0, counter = 0.
REQ-027 While sync_rst = 1: in_ready = 0, ser_valid = 0, ser_last = 0, ser_out = 0, regardless of other inputs.
REQ-028 Reset asserted mid-word SHALL discard the remaining bits; no partial word is resumed after release.
REQ-029 First cycle after release: in_ready = 1, ser_valid = 0.
REQ-030 Reset SHALL take priority over every simultaneous handshake.

Verification
REQ-031 WIDTH=4, MSB_FIRST=1, ser_ready=1, load 4'b1011 -> ser_out 1,0,1,1 over 4 cycles starting 1 cycle after load; ser_last high on 4th bit only; then IDLE.
REQ-032 MSB_FIRST=0, load 4'b1011 -> ser_out 1,1,0,1; ser_last on 4th bit.
REQ-033 Load 4'b1100, ser_ready low for 3 cycles after bit 1 -> ser_out holds 1, counter holds; sequence resumes 1,0,0 with no lost or duplicated bits.
REQ-034 Back-to-back 4'b1010 then 4'b0110, second word offered during last bit of first -> 8 consecutive valid bits 1,0,1,0,0,1,1,0, in_ready high only on last-bit cycle.
REQ-035 sync_rst pulsed after bit 2 of 4'b1111 -> ser_valid 0 next cycle, in_ready 1 after release, new word 4'b0001 serialized cleanly as 0,0,0,1.
REQ-036 in_valid held high with random in_data while in SHIFT, ser_last = 0 -> output stream matches the originally loaded word.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with valid/ready handshakes on both sides.
// A word is accepted while idle, or on the cycle its predecessor's last bit
// leaves, so a continuous supply of words streams out at one bit per clock.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [WIDTH-1:0]   shift_adv;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               out_bit;
  logic               in_shift;
  logic               word_xfer;
  logic               bit_xfer;

  // Shift register advanced by one position toward the output end, zero filled.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adv
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_fill
        assign shift_adv[gi] = 1'b0;
      end else begin : g_move
        assign shift_adv[gi] = shift_reg[gi-1];
      end
    end else begin : g_lsb
      if (gi == WIDTH - 1) begin : g_fill
        assign shift_adv[gi] = 1'b0;
      end else begin : g_move
        assign shift_adv[gi] = shift_reg[gi+1];
      end
    end
  end

  assign out_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

  // Handshake outputs and next-state decode; reset forces every output low.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;

    in_shift  = !sync_rst && (state_reg == SHIFT);
    ser_valid = in_shift;
    ser_last  = in_shift && (cnt_reg == CNT_MAX);
    ser_out   = in_shift && out_bit;
    // A new word may enter only when nothing is held or the held word is
    // leaving this very cycle, which makes in_ready follow ser_ready.
    in_ready  = !sync_rst && ((state_reg == IDLE) || (ser_last && ser_ready));

    word_xfer = in_valid && in_ready;
    bit_xfer  = ser_valid && ser_ready;

    case (state_reg)
      IDLE: begin
        if (word_xfer) begin
          shift_next = in_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_xfer) begin
          if (cnt_reg != CNT_MAX) begin
            shift_next = shift_adv;
            cnt_next   = cnt_reg + 1'b1;
          end else if (word_xfer) begin
            shift_next = in_data;
            cnt_next   = '0;
          end else begin
            shift_next = '0;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, data and bit-count registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share the
// same stimulus and are compared each cycle against a queue-of-bits model.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         sync_rst;
  logic         in_valid;
  logic         ser_ready;
  logic [W-1:0] in_data;

  logic rdy_m, out_m, val_m, last_m;
  logic rdy_l, out_l, val_l, last_l;

  int checks = 0;
  int fails  = 0;

  // Model: pending bits of the held word(s) in output order.
  bit q_m[$];
  bit q_l[$];

  // Observation of the accepted serial stream.
  logic [15:0] sm, sl;
  int nbits, nlast, nready_busy;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .sync_rst(sync_rst), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(in_data), .ser_out(out_m), .ser_valid(val_m), .ser_last(last_m),
    .ser_ready(ser_ready)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .sync_rst(sync_rst), .in_valid(in_valid), .in_ready(rdy_l),
    .in_data(in_data), .ser_out(out_l), .ser_valid(val_l), .ser_last(last_l),
    .ser_ready(ser_ready)
  );

  function automatic logic exp_ready();
    return !sync_rst && (q_m.size() == 0 || (q_m.size() == 1 && ser_ready));
  endfunction

  // Expected {ready, valid, last, out} for both instances.
  function automatic logic [7:0] exp_vec();
    logic v, l, om, ol;
    v  = !sync_rst && (q_m.size() > 0);
    l  = !sync_rst && (q_m.size() == 1);
    om = v ? q_m[0] : 1'b0;
    ol = v ? q_l[0] : 1'b0;
    return {exp_ready(), v, l, om, exp_ready(), v, l, ol};
  endfunction

  // ser_out only matters while a bit is offered or while reset forces it low.
  function automatic logic [7:0] obs_vec();
    logic keep;
    keep = sync_rst || (q_m.size() > 0);
    return {rdy_m, val_m, last_m, keep ? out_m : 1'b0,
            rdy_l, val_l, last_l, keep ? out_l : 1'b0};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic rst);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    ser_ready = r;
    sync_rst  = rst;
    #1;
  endtask

  // Advance the model by the handshakes of the current cycle, then clock.
  task automatic step();
    logic wx, bx;
    if (sync_rst) begin
      q_m.delete();
      q_l.delete();
    end else begin
      wx = in_valid && exp_ready();
      bx = (q_m.size() > 0) && ser_ready;
      if (bx) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (wx) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back(in_data[W-1-i]);
          q_l.push_back(in_data[i]);
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic clear_obs();
    sm = '0; sl = '0; nbits = 0; nlast = 0; nready_busy = 0;
  endtask

  task automatic record();
    if (val_m && ser_ready) begin
      sm = {sm[14:0], out_m};
      sl = {sl[14:0], out_l};
      nbits++;
    end
    if (last_m) nlast++;
    if (rdy_m && val_m) nready_busy++;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'($urandom), W'($urandom), 1'($urandom), 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if ({rdy_m, val_m, rdy_l, val_l} !== 4'b1010) begin
      fails++;
      $display("FAIL reset_release got=%b want=1010", {rdy_m, val_m, rdy_l, val_l});
    end
    step();
  endtask

  task automatic test_basic();
    clear_obs();
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 4'b1011, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL basic cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      record();
      step();
    end
    checks++;
    if (nbits != 4 || sm[3:0] !== 4'b1011) begin
      fails++;
      $display("FAIL basic_msb_stream got=%b n=%0d want=1011 n=4", sm[3:0], nbits);
    end
    checks++;
    if (sl[3:0] !== 4'b1101) begin
      fails++;
      $display("FAIL basic_lsb_stream got=%b want=1101", sl[3:0]);
    end
    checks++;
    if (nlast != 1) begin
      fails++;
      $display("FAIL basic_last_count got=%0d want=1", nlast);
    end
  endtask

  task automatic test_stall();
    clear_obs();
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, 4'b1100, (c < 2 || c > 4), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stall cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      record();
      step();
    end
    checks++;
    if (nbits != 4 || sm[3:0] !== 4'b1100 || sl[3:0] !== 4'b0011) begin
      fails++;
      $display("FAIL stall_stream got=%b/%b n=%0d want=1100/0011 n=4", sm[3:0], sl[3:0], nbits);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    for (int c = 0; c < 10; c++) begin
      drive(c == 0 || c == 4, (c == 0) ? 4'b1010 : 4'b0110, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL b2b cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      record();
      step();
    end
    checks++;
    if (nbits != 8 || sm[7:0] !== 8'b10100110 || sl[7:0] !== 8'b01010110) begin
      fails++;
      $display("FAIL b2b_stream got=%b/%b n=%0d want=10100110/01010110 n=8", sm[7:0], sl[7:0], nbits);
    end
    checks++;
    if (nready_busy != 2) begin
      fails++;
      $display("FAIL b2b_ready_while_busy got=%0d want=2", nready_busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    for (int c = 0; c < 10; c++) begin
      if (c == 4) clear_obs();
      drive(c == 0 || c == 4, (c == 0) ? 4'b1111 : 4'b0001, 1'b1, c == 3);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL reset_mid cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      if (c == 4) begin
        checks++;
        if ({rdy_m, val_m} !== 2'b10) begin
          fails++;
          $display("FAIL reset_mid_release got=%b want=10", {rdy_m, val_m});
        end
      end
      record();
      step();
    end
    checks++;
    if (nbits != 4 || sm[3:0] !== 4'b0001 || sl[3:0] !== 4'b1000) begin
      fails++;
      $display("FAIL reset_mid_stream got=%b/%b n=%0d want=0001/1000 n=4", sm[3:0], sl[3:0], nbits);
    end
  endtask

  task automatic test_ignore();
    logic [W-1:0] w, wr;
    logic v;
    w = W'($urandom);
    for (int i = 0; i < W; i++) wr[i] = w[W-1-i];
    clear_obs();
    for (int c = 0; c < 40 && nbits < W; c++) begin
      v = (c == 0) || (q_m.size() > 1);
      drive(v, (c == 0) ? w : W'($urandom), 1'($urandom), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL ignore cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      record();
      step();
    end
    checks++;
    if (nbits != W || sm[3:0] !== w || sl[3:0] !== wr) begin
      fails++;
      $display("FAIL ignore_stream got=%b/%b n=%0d want=%b/%b n=4", sm[3:0], sl[3:0], nbits, w, wr);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 49) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
      end
      step();
    end
  endtask

  initial begin
    sync_rst  = 1'b1;
    in_valid  = 1'b0;
    ser_ready = 1'b0;
    in_data   = '0;
    clear_obs();
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
